// File: rtl/pe_cmd_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pe_cmd_sequencer: drives RESET/SET_CONV_MODE/LOAD_DATA/TRIGGER for a  |
// | single-accumulation PE job, fetching operand pairs from two SRAMs.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pe_cmd_sequencer #(
  parameter int ACLEN      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  conv_len_in,
  input  logic [ADDR_WIDTH-1:0] data_base_in,
  input  logic [ADDR_WIDTH-1:0] weight_base_in,
  input  logic                  preload_en_in,
  input  logic [DATA_WIDTH-1:0] preload_val_in,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] data_rd_addr,
  output logic [ADDR_WIDTH-1:0] weight_rd_addr,
  input  logic [DATA_WIDTH-1:0] data_rd_data,
  input  logic [DATA_WIDTH-1:0] weight_rd_data,
  output logic                  pe_cmd_valid,
  output logic [ACLEN:0]        pe_cmd,
  output logic [DATA_WIDTH-1:0] param_1_out,
  output logic [DATA_WIDTH-1:0] param_2_out,
  output logic [DATA_WIDTH-1:0] preload_data_out,
  output logic [DATA_WIDTH-1:0] pe_data_out,
  output logic [DATA_WIDTH-1:0] pe_weight_out,
  input  logic                  pe_busy,
  output logic                  idle,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [ACLEN:0] CMD_RESET     = (ACLEN+1)'(0);
  localparam logic [ACLEN:0] CMD_TRIGGER   = (ACLEN+1)'(1);
  localparam logic [ACLEN:0] CMD_LOAD_DATA = (ACLEN+1)'(5);
  localparam logic [ACLEN:0] CMD_SET_MODE  = (ACLEN+1)'(6);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_CMD  = 3'd1,
    S_MODE_CMD = 3'd2,
    S_LOAD_CMD = 3'd3,
    S_STREAM   = 3'd4,
    S_DRAIN    = 3'd5,
    S_WAIT     = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] dbase_q, dbase_d;
  logic [ADDR_WIDTH-1:0] wbase_q, wbase_d;
  logic                  pre_en_q, pre_en_d;
  logic [DATA_WIDTH-1:0] pre_val_q, pre_val_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic                  trig_q, trig_d;
  logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  terr_q, terr_d;
  logic [DATA_WIDTH-1:0] pe_data_q, pe_data_d;
  logic [DATA_WIDTH-1:0] pe_weight_q, pe_weight_d;

  logic w_issue_rd;
  logic w_last_rd;

  assign w_last_rd = (rd_cnt_q == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      dbase_q     <= '0;
      wbase_q     <= '0;
      pre_en_q    <= 1'b0;
      pre_val_q   <= '0;
      rd_cnt_q    <= '0;
      trig_q      <= 1'b0;
      wait_cnt_q  <= '0;
      terr_q      <= 1'b0;
      pe_data_q   <= '0;
      pe_weight_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      dbase_q     <= dbase_d;
      wbase_q     <= wbase_d;
      pre_en_q    <= pre_en_d;
      pre_val_q   <= pre_val_d;
      rd_cnt_q    <= rd_cnt_d;
      trig_q      <= trig_d;
      wait_cnt_q  <= wait_cnt_d;
      terr_q      <= terr_d;
      pe_data_q   <= pe_data_d;
      pe_weight_q <= pe_weight_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    dbase_d      = dbase_q;
    wbase_d      = wbase_q;
    pre_en_d     = pre_en_q;
    pre_val_d    = pre_val_q;
    rd_cnt_d     = rd_cnt_q;
    trig_d       = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    terr_d       = terr_q;
    pe_data_d    = pe_data_q;
    pe_weight_d  = pe_weight_q;
    w_issue_rd   = 1'b0;
    rd_en        = 1'b0;
    pe_cmd_valid = 1'b0;
    pe_cmd       = '0;
    param_1_out  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = conv_len_in;
          dbase_d    = data_base_in;
          wbase_d    = weight_base_in;
          pre_en_d   = preload_en_in;
          pre_val_d  = preload_val_in;
          terr_d     = 1'b0;
          rd_cnt_d   = '0;
          wait_cnt_d = '0;
          state_d    = S_RST_CMD;
        end
      end
      S_RST_CMD: begin
        pe_cmd_valid = 1'b1;
        pe_cmd       = CMD_RESET;
        state_d      = (len_q == '0) ? S_DONE : S_MODE_CMD;
      end
      S_MODE_CMD: begin
        pe_cmd_valid = 1'b1;
        pe_cmd       = CMD_SET_MODE;
        param_1_out  = DATA_WIDTH'(len_q);
        // The first read overlaps the last command cycle so TRIGGERs follow without a gap.
        if (pre_en_q) state_d = S_LOAD_CMD;
        else          w_issue_rd = 1'b1;
      end
      S_LOAD_CMD: begin
        pe_cmd_valid = 1'b1;
        pe_cmd       = CMD_LOAD_DATA;
        w_issue_rd   = 1'b1;
      end
      S_STREAM: w_issue_rd = 1'b1;
      S_DRAIN: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        // PE busy lags the last TRIGGER by a cycle, so the first WAIT cycle is not trusted.
        if (wait_cnt_q != '0 && !pe_busy) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_issue_rd) begin
      rd_en    = 1'b1;
      rd_cnt_d = rd_cnt_q + LEN_WIDTH'(1);
      trig_d   = 1'b1;
      state_d  = w_last_rd ? S_DRAIN : S_STREAM;
    end

    if (trig_q) begin
      pe_cmd_valid = 1'b1;
      pe_cmd       = CMD_TRIGGER;
      pe_data_d    = data_rd_data;
      pe_weight_d  = weight_rd_data;
    end
  end

  assign data_rd_addr     = rd_en ? dbase_q + ADDR_WIDTH'(rd_cnt_q) : '0;
  assign weight_rd_addr   = rd_en ? wbase_q + ADDR_WIDTH'(rd_cnt_q) : '0;
  assign pe_data_out      = trig_q ? data_rd_data   : pe_data_q;
  assign pe_weight_out    = trig_q ? weight_rd_data : pe_weight_q;
  assign param_2_out      = '0;
  assign preload_data_out = pre_val_q;
  assign idle             = (state_q == S_IDLE);
  assign done             = (state_q == S_DONE);
  assign timeout_err      = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_cmd_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pe_cmd_sequencer: randomized jobs against a per-cycle job model.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_pe_cmd_sequencer;

  localparam int ACLEN = 8;
  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int LW    = 16;
  localparam int TO    = 16;
  localparam int MAXR  = 128;

  logic          clk_i = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] conv_len_in;
  logic [AW-1:0] data_base_in, weight_base_in;
  logic          preload_en_in;
  logic [DW-1:0] preload_val_in;
  logic          rd_en;
  logic [AW-1:0] data_rd_addr, weight_rd_addr;
  logic [DW-1:0] data_rd_data, weight_rd_data;
  logic          pe_cmd_valid;
  logic [ACLEN:0] pe_cmd;
  logic [DW-1:0] param_1_out, param_2_out, preload_data_out, pe_data_out, pe_weight_out;
  logic          pe_busy;
  logic          idle, done, timeout_err;

  always #5 clk_i = ~clk_i;

  pe_cmd_sequencer #(
    .ACLEN(ACLEN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst(rst), .start(start), .conv_len_in(conv_len_in),
    .data_base_in(data_base_in), .weight_base_in(weight_base_in),
    .preload_en_in(preload_en_in), .preload_val_in(preload_val_in),
    .rd_en(rd_en), .data_rd_addr(data_rd_addr), .weight_rd_addr(weight_rd_addr),
    .data_rd_data(data_rd_data), .weight_rd_data(weight_rd_data),
    .pe_cmd_valid(pe_cmd_valid), .pe_cmd(pe_cmd), .param_1_out(param_1_out),
    .param_2_out(param_2_out), .preload_data_out(preload_data_out),
    .pe_data_out(pe_data_out), .pe_weight_out(pe_weight_out), .pe_busy(pe_busy),
    .idle(idle), .done(done), .timeout_err(timeout_err)
  );

  // SRAM models: one-cycle read latency
  logic [DW-1:0] dmem [0:4095];
  logic [DW-1:0] wmem [0:4095];
  always @(posedge clk_i) begin
    if (rd_en) begin
      data_rd_data   <= dmem[data_rd_addr];
      weight_rd_data <= wmem[weight_rd_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  int cur_r = 0;
  int last_r, rst_eff;
  logic [DW-1:0] hold_d = '0, hold_w = '0;

  // expected per-cycle outputs, indexed by cycles after the start-sampling edge
  logic          e_valid [MAXR], e_rd [MAXR], e_busy [MAXR], e_done [MAXR];
  logic          e_idle [MAXR], e_terr [MAXR], e_trig [MAXR];
  logic [ACLEN:0] e_cmd [MAXR];
  logic [DW-1:0] e_p1 [MAXR], e_pd [MAXR], e_pw [MAXR], e_pre [MAXR];
  logic [AW-1:0] e_da [MAXR], e_wa [MAXR];

  // observed outputs of the latest job
  logic          o_valid [MAXR], o_rd [MAXR], o_done [MAXR], o_idle [MAXR], o_terr [MAXR];
  logic [ACLEN:0] o_cmd [MAXR];
  logic [DW-1:0] o_p1 [MAXR], o_pd [MAXR], o_pre [MAXR];
  logic [AW-1:0] o_da [MAXR], o_wa [MAXR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cur_r, act, exp);
    end
  endtask

  // Job model: the whole expected trace follows from L, the header length and the busy schedule.
  task automatic build(input int L, input int db, input int wb, input bit pre,
                       input logic [DW-1:0] pval, input int foff, input int rat);
    int nh, w0, dr, fall;
    bit tmo;
    logic [DW-1:0] hd, hw;
    for (int r = 0; r < MAXR; r++) begin
      e_valid[r] = 0; e_cmd[r] = '0; e_p1[r] = '0; e_rd[r] = 0; e_da[r] = '0; e_wa[r] = '0;
      e_busy[r] = 0; e_done[r] = 0; e_idle[r] = 0; e_terr[r] = 0; e_trig[r] = 0;
      e_pd[r] = '0; e_pw[r] = '0; e_pre[r] = pval;
    end
    nh = (L == 0) ? 1 : (pre ? 3 : 2);
    e_valid[1] = 1; e_cmd[1] = 0;
    if (L > 0) begin e_valid[2] = 1; e_cmd[2] = 6; e_p1[2] = DW'(L); end
    if (L > 0 && pre) begin e_valid[3] = 1; e_cmd[3] = 5; end
    for (int k = 0; k < L; k++) begin
      e_rd[nh+k] = 1; e_da[nh+k] = AW'(db + k); e_wa[nh+k] = AW'(wb + k);
      e_valid[nh+1+k] = 1; e_cmd[nh+1+k] = 1; e_trig[nh+1+k] = 1;
      e_pd[nh+1+k] = dmem[AW'(db + k)]; e_pw[nh+1+k] = wmem[AW'(wb + k)];
    end
    tmo = 0; dr = 0; w0 = 0;
    if (L == 0) dr = 2;
    else begin
      w0 = nh + L + 1;
      fall = (foff < 0) ? MAXR : nh + 2 + foff;
      for (int r = nh + 2; r < MAXR; r++) e_busy[r] = (r < fall);
      for (int r = w0 + 1; r <= w0 + TO - 1; r++)
        if (!e_busy[r]) begin dr = r + 1; break; end
    end
    if (dr != 0) begin e_done[dr] = 1; last_r = dr + 1; end
    else begin last_r = w0 + TO; tmo = 1; end
    hd = hold_d; hw = hold_w;
    for (int r = 1; r < MAXR; r++) begin
      if (e_trig[r]) begin hd = e_pd[r]; hw = e_pw[r]; end
      else begin e_pd[r] = hd; e_pw[r] = hw; end
      e_idle[r] = (r >= last_r);
      e_terr[r] = tmo && (r >= last_r);
    end
    rst_eff = 0;
    if (rat > 0 && rat + 1 < last_r) begin
      rst_eff = rat; last_r = rat + 1;
      e_valid[last_r] = 0; e_cmd[last_r] = '0; e_p1[last_r] = '0; e_rd[last_r] = 0;
      e_done[last_r] = 0; e_idle[last_r] = 1; e_terr[last_r] = 0;
      e_pd[last_r] = '0; e_pw[last_r] = '0; e_pre[last_r] = '0;
    end
  endtask

  task automatic run_job(input int L, input int db, input int wb, input bit pre,
                         input logic [DW-1:0] pval, input int foff, input int rat);
    build(L, db, wb, pre, pval, foff, rat);
    conv_len_in = LW'(L); data_base_in = AW'(db); weight_base_in = AW'(wb);
    preload_en_in = pre; preload_val_in = pval; start = 1; rst = 0; pe_busy = 0;
    @(posedge clk_i);
    for (int r = 1; r <= last_r; r++) begin
      @(negedge clk_i);
      cur_r   = r;
      pe_busy = e_busy[r];
      rst     = (r == rst_eff);
      start   = (r < last_r) && ($urandom_range(0, 3) == 0);
      conv_len_in = LW'($urandom); data_base_in = AW'($urandom);
      weight_base_in = AW'($urandom); preload_en_in = 1'($urandom);
      preload_val_in = $urandom;
      o_valid[r] = pe_cmd_valid; o_cmd[r] = pe_cmd; o_p1[r] = param_1_out; o_rd[r] = rd_en;
      o_da[r] = data_rd_addr; o_wa[r] = weight_rd_addr; o_pd[r] = pe_data_out;
      o_pre[r] = preload_data_out; o_done[r] = done; o_idle[r] = idle; o_terr[r] = timeout_err;
      chk("cmd_valid", 64'(pe_cmd_valid), 64'(e_valid[r]));
      chk("cmd", 64'(pe_cmd), 64'(e_cmd[r]));
      chk("param_1", 64'(param_1_out), 64'(e_p1[r]));
      chk("param_2", 64'(param_2_out), 64'(0));
      chk("rd_en", 64'(rd_en), 64'(e_rd[r]));
      if (e_rd[r]) begin
        chk("data_rd_addr", 64'(data_rd_addr), 64'(e_da[r]));
        chk("weight_rd_addr", 64'(weight_rd_addr), 64'(e_wa[r]));
      end
      chk("pe_data_out", 64'(pe_data_out), 64'(e_pd[r]));
      chk("pe_weight_out", 64'(pe_weight_out), 64'(e_pw[r]));
      chk("preload_data_out", 64'(preload_data_out), 64'(e_pre[r]));
      chk("idle", 64'(idle), 64'(e_idle[r]));
      chk("done", 64'(done), 64'(e_done[r]));
      chk("timeout_err", 64'(timeout_err), 64'(e_terr[r]));
    end
    hold_d = e_pd[last_r]; hold_w = e_pw[last_r];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, foff, rat, nd;
    for (int i = 0; i < 4096; i++) begin dmem[i] = $urandom; wmem[i] = $urandom; end
    rst = 1; start = 0; pe_busy = 0; conv_len_in = '0; data_base_in = '0; weight_base_in = '0;
    preload_en_in = 0; preload_val_in = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    cur_r = 0;
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_valid", 64'(pe_cmd_valid), 64'(0));
    chk("rst_cmd", 64'(pe_cmd), 64'(0));
    chk("rst_rd_en", 64'(rd_en), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));
    chk("rst_pe_data", 64'(pe_data_out), 64'(0));
    chk("rst_preload", 64'(preload_data_out), 64'(0));
    chk("rst_param_1", 64'(param_1_out), 64'(0));
    rst = 0;

    // L=4, SRAM holds 1.0..4.0, busy falls at cycle 12
    dmem[12'h010] = 32'h3F800000; dmem[12'h011] = 32'h40000000;
    dmem[12'h012] = 32'h40400000; dmem[12'h013] = 32'h40800000;
    run_job(4, 'h010, 'h200, 0, 32'h0, 8, 0);
    chk("lit_c1_reset_valid", 64'(o_valid[1]), 64'(1));
    chk("lit_c2_mode_cmd", 64'(o_cmd[2]), 64'(6));
    chk("lit_c2_param_1", 64'(o_p1[2]), 64'(4));
    chk("lit_c3_trig_data", 64'(o_pd[3]), 64'h3F800000);
    chk("lit_c6_trig_data", 64'(o_pd[6]), 64'h40800000);
    chk("lit_c5_daddr", 64'(o_da[5]), 64'h013);
    chk("lit_c5_waddr", 64'(o_wa[5]), 64'h203);
    chk("lit_c7_no_cmd", 64'(o_valid[7]), 64'(0));
    chk("lit_c13_done", 64'(o_done[13]), 64'(1));

    run_job(2, $urandom_range(0, 4095), $urandom_range(0, 4095), 1, 32'h40000000, 6, 0);
    chk("lit_pre_c3_cmd", 64'(o_cmd[3]), 64'(5));
    chk("lit_pre_c3_data", 64'(o_pre[3]), 64'h40000000);
    chk("lit_pre_c4_trig", 64'(o_cmd[4]), 64'(1));
    chk("lit_pre_c5_trig", 64'(o_cmd[5]), 64'(1));
    chk("lit_pre_c6_no_cmd", 64'(o_valid[6]), 64'(0));

    run_job(0, 'h123, 'h456, 0, 32'h0, 0, 0);
    chk("lit_l0_done_c2", 64'(o_done[2]), 64'(1));
    chk("lit_l0_idle_c3", 64'(o_idle[3]), 64'(1));

    run_job(4, 'hFFE, 'h7FF, 0, 32'h0, 3, 0);
    chk("lit_wrap_c3", 64'(o_da[3]), 64'hFFF);
    chk("lit_wrap_c4", 64'(o_da[4]), 64'h000);
    chk("lit_wrap_c5", 64'(o_da[5]), 64'h001);

    run_job(3, 'h040, 'h080, 0, 32'h0, -1, 0);
    nd = 0;
    for (int r = 1; r <= 22; r++) nd += int'(o_done[r]);
    chk("lit_to_no_done", 64'(nd), 64'(0));
    chk("lit_to_c21_terr", 64'(o_terr[21]), 64'(0));
    chk("lit_to_c22_terr", 64'(o_terr[22]), 64'(1));
    chk("lit_to_c22_idle", 64'(o_idle[22]), 64'(1));

    run_job(2, 'h300, 'h310, 0, 32'h0, 2, 0);
    chk("lit_next_start_clears_terr", 64'(o_terr[1]), 64'(0));

    run_job(8, 'h500, 'h600, 0, 32'h0, 10, 4);
    chk("lit_rst_idle", 64'(o_idle[5]), 64'(1));
    chk("lit_rst_no_cmd", 64'(o_valid[5]), 64'(0));
    chk("lit_rst_no_rd", 64'(o_rd[5]), 64'(0));

    for (int j = 0; j < 40; j++) begin
      L    = $urandom_range(0, 12);
      foff = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 30));
      rat  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 12)) : 0;
      run_job(L, $urandom_range(0, 4095), $urandom_range(0, 4095), 1'($urandom),
              $urandom, foff, rat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
